// File: rtl/ddr2_dq_calib_seq_pkg.sv
// Shared DDR2 calibration types: sequencer state encoding and watchdog defaults.
package ddr2_dq_calib_seq_pkg;

  typedef enum logic [1:0] {
    CAL_IDLE   = 2'd0,
    CAL_RUN    = 2'd1,
    CAL_FINISH = 2'd2
  } calib_state_t;

  localparam int MAX_BIT_CYCLES_DEF = 1024;
  localparam int WD_CNT_W           = 11;

endpackage

// File: rtl/ddr2_calib_watchdog.sv
// Per-stage cycle watchdog: counts while enabled, flags expiry combinationally when
// the count sits at LIMIT-1; synchronous clear has priority over counting.
module ddr2_calib_watchdog
  import ddr2_dq_calib_seq_pkg::*;
#(
  parameter int LIMIT = MAX_BIT_CYCLES_DEF,
  parameter int CNT_W = WD_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] cnt;

  generate
    if (LIMIT < 2 || LIMIT > (2 ** CNT_W)) begin : g_bad_limit
      $error("ddr2_calib_watchdog: LIMIT does not fit the counter width");
    end
  endgenerate

  assign expired = en && (cnt == CNT_W'(LIMIT - 1));

  // Counter holds at the limit; the owner decides what expiry means.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ddr2_dq_calib_seq.sv
// Walks DQ bits one at a time in front of the per-bit tap controller: muxes the selected
// bit's data in and routes dlyce/dlyinc out with zero latency; advances on chan_done.
module ddr2_dq_calib_seq
  import ddr2_dq_calib_seq_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int SEL_W          = 4,
  parameter int MAX_BIT_CYCLES = MAX_BIT_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  calib_en,
  input  logic [DATA_WIDTH-1:0] dq_in,
  input  logic                  tap_dlyce,
  input  logic                  tap_dlyinc,
  input  logic                  tap_chan_done,
  output logic                  tap_start,
  output logic                  dq_data,
  output logic [DATA_WIDTH-1:0] dlyce,
  output logic [DATA_WIDTH-1:0] dlyinc,
  output logic [SEL_W-1:0]      bit_sel,
  output logic [DATA_WIDTH-1:0] bits_done,
  output logic                  calib_done,
  output logic                  calib_err
);

  localparam int              SEL_W_REQ = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [SEL_W-1:0] LAST_BIT = SEL_W'(DATA_WIDTH - 1);

  generate
    if (SEL_W != SEL_W_REQ) begin : g_bad_sel_w
      $error("ddr2_dq_calib_seq: SEL_W must equal clog2(DATA_WIDTH)");
    end
  endgenerate

  calib_state_t          state, state_nxt;
  logic [SEL_W-1:0]      bit_sel_nxt;
  logic [DATA_WIDTH-1:0] bits_done_nxt;
  logic                  calib_done_nxt;
  logic                  calib_err_nxt;
  logic                  wd_en;
  logic                  wd_clr;
  logic                  wd_expired;

  assign wd_en  = (state == CAL_RUN);
  assign wd_clr = (state != CAL_RUN) || tap_chan_done;

  ddr2_calib_watchdog #(
    .LIMIT (MAX_BIT_CYCLES),
    .CNT_W (WD_CNT_W)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= CAL_IDLE;
      bit_sel    <= '0;
      bits_done  <= '0;
      calib_done <= 1'b0;
      calib_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_sel    <= bit_sel_nxt;
      bits_done  <= bits_done_nxt;
      calib_done <= calib_done_nxt;
      calib_err  <= calib_err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    bit_sel_nxt    = bit_sel;
    bits_done_nxt  = bits_done;
    calib_done_nxt = calib_done;
    calib_err_nxt  = calib_err;
    tap_start      = 1'b0;
    dq_data        = 1'b0;
    dlyce          = '0;
    dlyinc         = '0;

    case (state)
      CAL_IDLE: begin
        if (!calib_en) begin
          bit_sel_nxt    = '0;
          bits_done_nxt  = '0;
          calib_done_nxt = 1'b0;
          calib_err_nxt  = 1'b0;
        end else if (!calib_done) begin
          state_nxt = CAL_RUN;
        end
      end

      CAL_RUN: begin
        tap_start = 1'b1;
        dq_data   = dq_in[bit_sel];
        // tap_dlyce is combinational in the controller, so no register here.
        for (int i = 0; i < DATA_WIDTH; i++) begin
          dlyce[i]  = tap_dlyce  && (bit_sel == SEL_W'(i));
          dlyinc[i] = tap_dlyinc && (bit_sel == SEL_W'(i));
        end

        if (!calib_en) begin
          state_nxt     = CAL_IDLE;
          bit_sel_nxt   = '0;
          bits_done_nxt = '0;
        end else if (tap_chan_done) begin
          bits_done_nxt[bit_sel] = 1'b1;
          if (bit_sel == LAST_BIT) begin
            state_nxt      = CAL_FINISH;
            calib_done_nxt = 1'b1;
          end else begin
            // Controller's PIPE_WAIT cycle gives the new select time to settle.
            bit_sel_nxt = bit_sel + SEL_W'(1);
          end
        end else if (wd_expired) begin
          state_nxt      = CAL_FINISH;
          calib_err_nxt  = 1'b1;
          calib_done_nxt = 1'b1;
        end
      end

      CAL_FINISH: begin
        if (!calib_en) begin
          state_nxt = CAL_IDLE;
        end
      end

      default: begin
        state_nxt = CAL_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ddr2_dq_calib_seq.sv
// Scoreboard bench for ddr2_dq_calib_seq with a short watchdog (64 cycles).
module tb_ddr2_dq_calib_seq;

  logic        clk;
  logic        reset;
  logic        calib_en;
  logic [15:0] dq_in;
  logic        tap_dlyce;
  logic        tap_dlyinc;
  logic        tap_chan_done;
  logic        tap_start;
  logic        dq_data;
  logic [15:0] dlyce;
  logic [15:0] dlyinc;
  logic [3:0]  bit_sel;
  logic [15:0] bits_done;
  logic        calib_done;
  logic        calib_err;

  int vectors;
  int miscompares;

  typedef struct {
    logic [15:0] done;
    logic [3:0]  sel;
    logic        cdone;
  } exp_t;

  exp_t        exp_q[$];
  int          m_bit;
  logic [15:0] m_done;

  ddr2_dq_calib_seq #(
    .DATA_WIDTH     (16),
    .SEL_W          (4),
    .MAX_BIT_CYCLES (64)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .calib_en      (calib_en),
    .dq_in         (dq_in),
    .tap_dlyce     (tap_dlyce),
    .tap_dlyinc    (tap_dlyinc),
    .tap_chan_done (tap_chan_done),
    .tap_start     (tap_start),
    .dq_data       (dq_data),
    .dlyce         (dlyce),
    .dlyinc        (dlyinc),
    .bit_sel       (bit_sel),
    .bits_done     (bits_done),
    .calib_done    (calib_done),
    .calib_err     (calib_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_bit  = 0;
    m_done = '0;
  endtask

  // One-cycle chan_done pulse; expected post-edge state goes to the scoreboard.
  task automatic pulse_done();
    exp_t e;
    logic [15:0] one;
    one     = 16'h0001 << m_bit;
    e.done  = m_done | one;
    e.sel   = (m_bit == 15) ? 4'd15 : 4'(m_bit + 1);
    e.cdone = (m_bit == 15);
    exp_q.push_back(e);
    m_done = e.done;
    if (m_bit != 15) m_bit = m_bit + 1;
    tap_chan_done = 1'b1;
    tick();
    tap_chan_done = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if ({tap_start, dq_data, calib_done, calib_err, bit_sel, bits_done, dlyce, dlyinc} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got sel=%0d done=%h cd=%b ce=%b start=%b want all zero",
               bit_sel, bits_done, calib_done, calib_err, tap_start);
    end
    tick();
    reset = 1'b0;
    tick();
    tick();
    vectors++;
    if (tap_start !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle_start got %b want 0", tap_start);
    end
  endtask

  task automatic test_nominal();
    exp_t e;
    model_clear();
    calib_en = 1'b1;
    tick();
    for (int b = 0; b < 16; b++) begin
      vectors++;
      if (bit_sel !== 4'(b) || tap_start !== 1'b1) begin
        miscompares++;
        $display("FAIL nom_select got sel=%0d start=%b want sel=%0d start=1", bit_sel, tap_start, b);
      end
      repeat (39) tick();
      pulse_done();
      e = exp_q.pop_front();
      vectors++;
      if (bits_done !== e.done || bit_sel !== e.sel || calib_done !== e.cdone) begin
        miscompares++;
        $display("FAIL nom_advance got done=%h sel=%0d cd=%b want done=%h sel=%0d cd=%b",
                 bits_done, bit_sel, calib_done, e.done, e.sel, e.cdone);
      end
    end
    vectors++;
    if (tap_start !== 1'b0 || calib_err !== 1'b0) begin
      miscompares++;
      $display("FAIL nom_finish got start=%b err=%b want 0 0", tap_start, calib_err);
    end
    tap_chan_done = 1'b1;
    tick();
    tap_chan_done = 1'b0;
    tick();
    vectors++;
    if (bits_done !== 16'hFFFF || calib_done !== 1'b1 || tap_start !== 1'b0) begin
      miscompares++;
      $display("FAIL nom_spurious_finish got done=%h cd=%b start=%b want ffff 1 0",
               bits_done, calib_done, tap_start);
    end
    calib_en = 1'b0;
    tick();
    tick();
    vectors++;
    if (calib_done !== 1'b0 || bits_done !== 16'h0000) begin
      miscompares++;
      $display("FAIL nom_idle_clear got cd=%b done=%h want 0 0000", calib_done, bits_done);
    end
  endtask

  task automatic test_routing();
    exp_t e;
    model_clear();
    calib_en = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      pulse_done();
      e = exp_q.pop_front();
      vectors++;
      if (bits_done !== e.done || bit_sel !== e.sel) begin
        miscompares++;
        $display("FAIL route_step got done=%h sel=%0d want done=%h sel=%0d",
                 bits_done, bit_sel, e.done, e.sel);
      end
    end
    tap_dlyce  = 1'b1;
    tap_dlyinc = 1'b1;
    #1;
    vectors++;
    if (dlyce !== 16'h0020 || dlyinc !== 16'h0020) begin
      miscompares++;
      $display("FAIL route_dly got ce=%h inc=%h want 0020 0020", dlyce, dlyinc);
    end
    tap_dlyce = 1'b0;
    #1;
    vectors++;
    if (dlyce !== 16'h0000 || dlyinc !== 16'h0020) begin
      miscompares++;
      $display("FAIL route_inc_only got ce=%h inc=%h want 0000 0020", dlyce, dlyinc);
    end
    tap_dlyinc = 1'b0;
    dq_in = 16'h0020;
    #1;
    vectors++;
    if (dq_data !== 1'b1) begin
      miscompares++;
      $display("FAIL route_dq_one got %b want 1", dq_data);
    end
    dq_in = 16'hFFDF;
    #1;
    vectors++;
    if (dq_data !== 1'b0) begin
      miscompares++;
      $display("FAIL route_dq_zero got %b want 0", dq_data);
    end
    dq_in = 16'h0000;
  endtask

  task automatic test_abort();
    exp_t e;
    repeat (2) begin
      pulse_done();
      e = exp_q.pop_front();
      vectors++;
      if (bits_done !== e.done || bit_sel !== e.sel) begin
        miscompares++;
        $display("FAIL abort_step got done=%h sel=%0d want done=%h sel=%0d",
                 bits_done, bit_sel, e.done, e.sel);
      end
    end
    calib_en = 1'b0;
    tick();
    vectors++;
    if (tap_start !== 1'b0 || bit_sel !== 4'd0 || bits_done !== 16'h0000) begin
      miscompares++;
      $display("FAIL abort_idle got start=%b sel=%0d done=%h want 0 0 0000", tap_start, bit_sel, bits_done);
    end
    tap_dlyce = 1'b1;
    #1;
    vectors++;
    if (dlyce !== 16'h0000) begin
      miscompares++;
      $display("FAIL abort_dlyce_idle got %h want 0000", dlyce);
    end
    tap_dlyce = 1'b0;
    model_clear();
    calib_en = 1'b1;
    tick();
    vectors++;
    if (tap_start !== 1'b1 || bit_sel !== 4'd0) begin
      miscompares++;
      $display("FAIL abort_restart got start=%b sel=%0d want 1 0", tap_start, bit_sel);
    end
    pulse_done();
    e = exp_q.pop_front();
    vectors++;
    if (bits_done !== e.done || bit_sel !== e.sel) begin
      miscompares++;
      $display("FAIL abort_restart_step got done=%h sel=%0d want done=%h sel=%0d",
               bits_done, bit_sel, e.done, e.sel);
    end
    calib_en = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_watchdog();
    exp_t e;
    model_clear();
    calib_en = 1'b1;
    tick();
    repeat (3) begin
      pulse_done();
      e = exp_q.pop_front();
      vectors++;
      if (bits_done !== e.done) begin
        miscompares++;
        $display("FAIL wd_step got done=%h want %h", bits_done, e.done);
      end
    end
    repeat (63) tick();
    vectors++;
    if (calib_err !== 1'b0 || tap_start !== 1'b1) begin
      miscompares++;
      $display("FAIL wd_early got err=%b start=%b want 0 1", calib_err, tap_start);
    end
    tick();
    vectors++;
    if (calib_err !== 1'b1 || calib_done !== 1'b1 || bits_done !== 16'h0007 ||
        tap_start !== 1'b0 || bit_sel !== 4'd3) begin
      miscompares++;
      $display("FAIL wd_expire got err=%b cd=%b done=%h start=%b sel=%0d want 1 1 0007 0 3",
               calib_err, calib_done, bits_done, tap_start, bit_sel);
    end
    tap_chan_done = 1'b1;
    tick();
    tap_chan_done = 1'b0;
    vectors++;
    if (bits_done !== 16'h0007 || bit_sel !== 4'd3 || calib_err !== 1'b1) begin
      miscompares++;
      $display("FAIL wd_spurious got done=%h sel=%0d err=%b want 0007 3 1", bits_done, bit_sel, calib_err);
    end
    calib_en = 1'b0;
    tick();
    tick();
    vectors++;
    if (calib_err !== 1'b0 || calib_done !== 1'b0) begin
      miscompares++;
      $display("FAIL wd_clear got err=%b cd=%b want 0 0", calib_err, calib_done);
    end
  endtask

  task automatic test_boundary();
    exp_t e;
    model_clear();
    calib_en = 1'b1;
    tick();
    repeat (2) begin
      pulse_done();
      e = exp_q.pop_front();
      vectors++;
      if (bits_done !== e.done) begin
        miscompares++;
        $display("FAIL bnd_step got done=%h want %h", bits_done, e.done);
      end
    end
    repeat (63) tick();
    pulse_done();
    e = exp_q.pop_front();
    vectors++;
    if (bits_done !== e.done || bit_sel !== e.sel || calib_err !== 1'b0 || tap_start !== 1'b1) begin
      miscompares++;
      $display("FAIL bnd_done_wins got done=%h sel=%0d err=%b start=%b want done=%h sel=%0d err=0 start=1",
               bits_done, bit_sel, calib_err, tap_start, e.done, e.sel);
    end
    calib_en = 1'b0;
    tick();
    tick();
    tap_chan_done = 1'b1;
    tick();
    tap_chan_done = 1'b0;
    vectors++;
    if (bits_done !== 16'h0000 || tap_start !== 1'b0 || bit_sel !== 4'd0) begin
      miscompares++;
      $display("FAIL bnd_spurious_idle got done=%h start=%b sel=%0d want 0000 0 0", bits_done, tap_start, bit_sel);
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    model_clear();
    calib_en = 1'b1;
    tick();
    repeat (2) begin
      pulse_done();
      e = exp_q.pop_front();
      vectors++;
      if (bits_done !== e.done || bit_sel !== e.sel) begin
        miscompares++;
        $display("FAIL arst_step got done=%h sel=%0d want done=%h sel=%0d",
                 bits_done, bit_sel, e.done, e.sel);
      end
    end
    tap_dlyce = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if ({tap_start, calib_done, calib_err, bit_sel, bits_done, dlyce, dlyinc} !== '0) begin
      miscompares++;
      $display("FAIL arst_immediate got sel=%0d done=%h start=%b ce=%h want all zero",
               bit_sel, bits_done, tap_start, dlyce);
    end
    tap_dlyce = 1'b0;
    calib_en  = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    tick();
    vectors++;
    if (tap_start !== 1'b0 || bit_sel !== 4'd0) begin
      miscompares++;
      $display("FAIL arst_hold_idle got start=%b sel=%0d want 0 0", tap_start, bit_sel);
    end
    model_clear();
    calib_en = 1'b1;
    tick();
    vectors++;
    if (tap_start !== 1'b1 || bit_sel !== 4'd0) begin
      miscompares++;
      $display("FAIL arst_resume got start=%b sel=%0d want 1 0", tap_start, bit_sel);
    end
    pulse_done();
    e = exp_q.pop_front();
    vectors++;
    if (bits_done !== e.done || bit_sel !== e.sel) begin
      miscompares++;
      $display("FAIL arst_resume_step got done=%h sel=%0d want done=%h sel=%0d",
               bits_done, bit_sel, e.done, e.sel);
    end
    calib_en = 1'b0;
    tick();
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    reset         = 1'b1;
    calib_en      = 1'b0;
    dq_in         = '0;
    tap_dlyce     = 1'b0;
    tap_dlyinc    = 1'b0;
    tap_chan_done = 1'b0;
    model_clear();
    test_reset();
    test_nominal();
    test_routing();
    test_abort();
    test_watchdog();
    test_boundary();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
